// File: rtl/conv_pkg.sv
// Shared definitions for the convolution core: FSM state encoding and
// default geometry of the X/Y/Z memories.
package conv_pkg;

   localparam int DATA_WIDTH_DEF  = 8;
   localparam int ADDR_WIDTH_DEF  = 5;
   localparam int ZADDR_WIDTH_DEF = 6;
   localparam int ZDATA_WIDTH_DEF = 16;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      READ,
      MAC,
      WRITE,
      DONE
   } conv_state_t;

endpackage

// File: rtl/conv_core_if.sv
// Memory-side bus of the convolution core: two read ports (X, Y) with
// one-cycle read latency and one write port (Z).
interface conv_core_if
   import conv_pkg::*;
#(
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
   parameter int ZADDR_WIDTH = ZADDR_WIDTH_DEF,
   parameter int ZDATA_WIDTH = ZDATA_WIDTH_DEF
);

   logic [ADDR_WIDTH-1:0]  memX_addr;
   logic                   memX_rd;
   logic [DATA_WIDTH-1:0]  memX_data;
   logic [ADDR_WIDTH-1:0]  memY_addr;
   logic                   memY_rd;
   logic [DATA_WIDTH-1:0]  memY_data;
   logic [ZADDR_WIDTH-1:0] memZ_addr;
   logic [ZDATA_WIDTH-1:0] memZ_data;
   logic                   memZ_we;

   modport master (
      output memX_addr, memX_rd, input memX_data,
      output memY_addr, memY_rd, input memY_data,
      output memZ_addr, memZ_data, memZ_we
   );

   modport slave (
      input memX_addr, memX_rd, output memX_data,
      input memY_addr, memY_rd, output memY_data,
      input memZ_addr, memZ_data, memZ_we
   );

endinterface

// File: rtl/conv_mac.sv
// Unsigned multiply-accumulate: acc <= acc + a*b when enabled, cleared
// synchronously between output words.
module conv_mac
   import conv_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ACC_WIDTH  = 2*DATA_WIDTH_DEF + ADDR_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  enable,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [ACC_WIDTH-1:0]  acc
);

   logic [2*DATA_WIDTH-1:0] product;

   assign product = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (enable) begin
         acc <= acc + ACC_WIDTH'(product);
      end
   end

endmodule

// File: rtl/conv_core.sv
// Full linear convolution z = x * y over external X/Y memories, one MAC
// per READ/MAC cycle pair, results written word by word to external Z.
module conv_core
   import conv_pkg::*;
#(
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
   parameter int ZADDR_WIDTH = ZADDR_WIDTH_DEF,
   parameter int ZDATA_WIDTH = ZDATA_WIDTH_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [ADDR_WIDTH:0] sizeX,
   input  logic [ADDR_WIDTH:0] sizeY,
   conv_core_if.master         mem,
   output logic                busy,
   output logic                done
);

   localparam int ACC_WIDTH = 2*DATA_WIDTH + ADDR_WIDTH;
   // Index arithmetic width: holds i up to 2*32-2 plus one guard bit.
   localparam int CW = ZADDR_WIDTH + 1;
   localparam logic [CW-1:0] ONE_W = CW'(1);
   localparam logic [CW-1:0] TWO_W = CW'(2);

   conv_state_t state, next_state;

   logic [ADDR_WIDTH:0]    size_x, size_y;
   logic [ZADDR_WIDTH-1:0] i;
   logic [ADDR_WIDTH-1:0]  k, k_end;
   logic [ACC_WIDTH-1:0]   acc;

   logic [CW-1:0]          i_w, sx_w, sy_w;
   logic [ADDR_WIDTH-1:0]  k_start_c, k_end_c, y_addr_c;
   logic                   last_i, more_taps;

   assign i_w       = CW'(i);
   assign sx_w      = CW'(size_x);
   assign sy_w      = CW'(size_y);
   assign last_i    = (i_w == sx_w + sy_w - TWO_W);
   assign more_taps = (k < k_end);
   assign y_addr_c  = ADDR_WIDTH'(i_w - CW'(k));

   // Tap window for output i: k in [max(0, i-sizeY+1), min(i, sizeX-1)].
   always_comb begin
      k_start_c = '0;
      k_end_c   = ADDR_WIDTH'(sx_w - ONE_W);
      if (i_w >= sy_w)
         k_start_c = ADDR_WIDTH'(i_w - sy_w + ONE_W);
      if (i_w < sx_w - ONE_W)
         k_end_c = ADDR_WIDTH'(i_w);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         size_x <= '0;
         size_y <= '0;
         i      <= '0;
         k      <= '0;
         k_end  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  size_x <= sizeX;
                  size_y <= sizeY;
                  i      <= '0;
               end
            end
            SETUP: begin
               k     <= k_start_c;
               k_end <= k_end_c;
            end
            MAC: begin
               if (more_taps)
                  k <= k + 1'b1;
            end
            WRITE: begin
               if (!last_i)
                  i <= i + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // NOTE: every output of this block gets a default before the case so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      next_state    = state;
      busy          = (state != IDLE);
      done          = 1'b0;
      mem.memX_rd   = 1'b0;
      mem.memY_rd   = 1'b0;
      mem.memX_addr = '0;
      mem.memY_addr = '0;
      mem.memZ_we   = 1'b0;
      mem.memZ_addr = '0;
      mem.memZ_data = '0;
      case (state)
         IDLE: begin
            if (start)
               next_state = (sizeX == '0 || sizeY == '0) ? DONE : SETUP;
         end
         SETUP: next_state = READ;
         READ: begin
            mem.memX_rd   = 1'b1;
            mem.memY_rd   = 1'b1;
            mem.memX_addr = k;
            mem.memY_addr = y_addr_c;
            next_state    = MAC;
         end
         MAC: next_state = more_taps ? READ : WRITE;
         WRITE: begin
            mem.memZ_we   = 1'b1;
            mem.memZ_addr = i;
            mem.memZ_data = ZDATA_WIDTH'(acc);
            next_state    = last_i ? DONE : SETUP;
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   conv_mac #(
      .DATA_WIDTH(DATA_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
   ) u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (state == SETUP),
      .enable(state == MAC),
      .a     (mem.memX_data),
      .b     (mem.memY_data),
      .acc   (acc)
   );

endmodule

// File: tb/tb_conv_core.sv
// Directed testbench for conv_core with behavioural X/Y memories and a
// Z-write monitor; expected results are hand-computed convolutions.
module tb_conv_core;
   import conv_pkg::*;

   localparam int DW  = 8;
   localparam int AW  = 5;
   localparam int ZAW = 6;
   localparam int ZDW = 16;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic [AW:0]   sizeX = '0;
   logic [AW:0]   sizeY = '0;
   logic          busy, done;

   int errors = 0;
   int checks = 0;

   conv_core_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZADDR_WIDTH(ZAW), .ZDATA_WIDTH(ZDW)) bus ();

   conv_core #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZADDR_WIDTH(ZAW), .ZDATA_WIDTH(ZDW)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .sizeX(sizeX),
      .sizeY(sizeY),
      .mem  (bus.master),
      .busy (busy),
      .done (done)
   );

   always #5 clk = ~clk;

   logic [DW-1:0] x_mem [32];
   logic [DW-1:0] y_mem [32];

   always @(posedge clk) begin
      if (bus.memX_rd) bus.memX_data <= x_mem[bus.memX_addr];
      if (bus.memY_rd) bus.memY_data <= y_mem[bus.memY_addr];
   end

   logic [ZAW-1:0] z_addr_q [$];
   logic [ZDW-1:0] z_data_q [$];
   int rd_count, done_count, proto_count, writes_at_done;

   always @(negedge clk) begin
      if (bus.memX_rd || bus.memY_rd) rd_count++;
      if ((bus.memX_rd || bus.memY_rd) && bus.memZ_we) proto_count++;
      if (bus.memX_rd !== bus.memY_rd) proto_count++;
      if (bus.memZ_we) begin
         z_addr_q.push_back(bus.memZ_addr);
         z_data_q.push_back(bus.memZ_data);
      end
      if (done) begin
         done_count++;
         writes_at_done = z_addr_q.size();
      end
   end

   task automatic clear_mon();
      z_addr_q.delete();
      z_data_q.delete();
      rd_count       = 0;
      done_count     = 0;
      proto_count    = 0;
      writes_at_done = -1;
   endtask

   // Caller is just past a negedge. Returns n = cycles from start to done.
   task automatic do_run(input logic [AW:0] sx, input logic [AW:0] sy,
                         input int restart_at, input int max_cycles, output int n);
      clear_mon();
      start = 1'b1;
      sizeX = sx;
      sizeY = sy;
      n     = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) start = 1'b0;
         if (restart_at != 0 && n == restart_at) begin
            start = 1'b1;
            sizeX = 1;
            sizeY = 1;
         end else if (restart_at != 0 && n == restart_at + 1) begin
            start = 1'b0;
         end
      end while (done !== 1'b1 && n < max_cycles);
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL run_timeout: done not seen within %0d cycles (sizes %0d x %0d)", max_cycles, sx, sy);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00) begin
         errors++;
         $display("FAIL reset_status: busy/done=%b expected 00", {busy, done});
      end
      checks++;
      if ({bus.memX_rd, bus.memY_rd, bus.memZ_we} !== 3'b000) begin
         errors++;
         $display("FAIL reset_strobes: rdX/rdY/we=%b expected 000", {bus.memX_rd, bus.memY_rd, bus.memZ_we});
      end
      checks++;
      if ({bus.memX_addr, bus.memY_addr, bus.memZ_addr, bus.memZ_data} !== '0) begin
         errors++;
         $display("FAIL reset_buses: addrX=%h addrY=%h addrZ=%h dataZ=%h expected all 0",
                  bus.memX_addr, bus.memY_addr, bus.memZ_addr, bus.memZ_data);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int n;
      logic [ZDW-1:0] exp_z [4];
      exp_z = '{16'd1, 16'd3, 16'd5, 16'd3};
      x_mem[0] = 8'd1; x_mem[1] = 8'd2; x_mem[2] = 8'd3;
      y_mem[0] = 8'd1; y_mem[1] = 8'd1;
      do_run(3, 2, 0, 100, n);
      checks++;
      if (z_addr_q.size() != 4) begin
         errors++;
         $display("FAIL basic_count: writes=%0d expected 4", z_addr_q.size());
      end
      for (int j = 0; j < 4 && j < z_addr_q.size(); j++) begin
         checks++;
         if (z_addr_q[j] !== ZAW'(j) || z_data_q[j] !== exp_z[j]) begin
            errors++;
            $display("FAIL basic_z%0d: addr=%0d data=%0d expected addr=%0d data=%0d",
                     j, z_addr_q[j], z_data_q[j], j, exp_z[j]);
         end
      end
      checks++;
      if (done_count != 1 || writes_at_done != 4) begin
         errors++;
         $display("FAIL basic_done: pulses=%0d writes_before=%0d expected 1 and 4", done_count, writes_at_done);
      end
      checks++;
      if (n != 21) begin
         errors++;
         $display("FAIL basic_latency: done after %0d cycles expected 21", n);
      end
      checks++;
      if (rd_count != 6 || proto_count != 0) begin
         errors++;
         $display("FAIL basic_reads: reads=%0d protocol_errs=%0d expected 6 and 0", rd_count, proto_count);
      end
   endtask

   task automatic test_single_max();
      int n;
      x_mem[0] = 8'hFF;
      y_mem[0] = 8'hFF;
      @(negedge clk);
      do_run(1, 1, 0, 20, n);
      checks++;
      if (z_addr_q.size() != 1 || z_addr_q[0] !== '0 || z_data_q[0] !== 16'hFE01) begin
         errors++;
         $display("FAIL single_z: writes=%0d first addr=%0d data=%h expected 1 write addr0=fe01",
                  z_addr_q.size(), z_addr_q.size() > 0 ? z_addr_q[0] : '0, z_data_q.size() > 0 ? z_data_q[0] : '0);
      end
      checks++;
      if (n != 5) begin
         errors++;
         $display("FAIL single_latency: done after %0d cycles expected 5", n);
      end
   endtask

   task automatic test_wrap();
      int n;
      logic [ZDW-1:0] exp_z [3];
      exp_z = '{16'hFE01, 16'hFC02, 16'hFE01};
      x_mem[0] = 8'hFF; x_mem[1] = 8'hFF;
      y_mem[0] = 8'hFF; y_mem[1] = 8'hFF;
      @(negedge clk);
      do_run(2, 2, 0, 50, n);
      checks++;
      if (z_addr_q.size() != 3 || n != 15) begin
         errors++;
         $display("FAIL wrap_count: writes=%0d cycles=%0d expected 3 and 15", z_addr_q.size(), n);
      end
      for (int j = 0; j < 3 && j < z_addr_q.size(); j++) begin
         checks++;
         if (z_addr_q[j] !== ZAW'(j) || z_data_q[j] !== exp_z[j]) begin
            errors++;
            $display("FAIL wrap_z%0d: addr=%0d data=%h expected addr=%0d data=%h",
                     j, z_addr_q[j], z_data_q[j], j, exp_z[j]);
         end
      end
   endtask

   task automatic test_zero_size();
      @(negedge clk);
      clear_mon();
      start = 1'b1;
      sizeX = 0;
      sizeY = 3;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({busy, done} !== 2'b11) begin
         errors++;
         $display("FAIL zero_next: busy/done=%b expected 11", {busy, done});
      end
      @(negedge clk);
      checks++;
      if ({busy, done} !== 2'b00) begin
         errors++;
         $display("FAIL zero_idle: busy/done=%b expected 00", {busy, done});
      end
      repeat (2) @(negedge clk);
      checks++;
      if (rd_count != 0 || z_addr_q.size() != 0 || done_count != 1) begin
         errors++;
         $display("FAIL zero_activity: reads=%0d writes=%0d dones=%0d expected 0 0 1",
                  rd_count, z_addr_q.size(), done_count);
      end
   endtask

   task automatic check_4x4(input string tag, input int n);
      logic [ZDW-1:0] exp_z [7];
      exp_z = '{16'd5, 16'd16, 16'd34, 16'd60, 16'd61, 16'd52, 16'd32};
      checks++;
      if (z_addr_q.size() != 7 || n != 47 || done_count != 1) begin
         errors++;
         $display("FAIL %s_count: writes=%0d cycles=%0d dones=%0d expected 7 47 1",
                  tag, z_addr_q.size(), n, done_count);
      end
      for (int j = 0; j < 7 && j < z_addr_q.size(); j++) begin
         checks++;
         if (z_addr_q[j] !== ZAW'(j) || z_data_q[j] !== exp_z[j]) begin
            errors++;
            $display("FAIL %s_z%0d: addr=%0d data=%0d expected addr=%0d data=%0d",
                     tag, j, z_addr_q[j], z_data_q[j], j, exp_z[j]);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      int n, cnt, zc;
      for (int j = 0; j < 4; j++) begin
         x_mem[j] = DW'(j + 1);
         y_mem[j] = DW'(j + 5);
      end
      @(negedge clk);
      clear_mon();
      start = 1'b1;
      sizeX = 4;
      sizeY = 4;
      @(negedge clk);
      start = 1'b0;
      cnt = 0;
      while (z_addr_q.size() < 2 && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      while (bus.memX_rd !== 1'b1 && cnt < 200) begin
         @(negedge clk);
         cnt++;
      end
      checks++;
      if (cnt >= 200) begin
         errors++;
         $display("FAIL midrun_timeout: no READ after 2 writes within 200 cycles");
      end
      @(posedge clk);
      #2;
      zc = z_addr_q.size();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, bus.memX_rd, bus.memY_rd, bus.memZ_we} !== 5'b0) begin
         errors++;
         $display("FAIL midrun_strobes: busy/done/rdX/rdY/we=%b expected 00000",
                  {busy, done, bus.memX_rd, bus.memY_rd, bus.memZ_we});
      end
      checks++;
      if ({bus.memX_addr, bus.memY_addr, bus.memZ_addr, bus.memZ_data} !== '0) begin
         errors++;
         $display("FAIL midrun_buses: addrX=%h addrY=%h addrZ=%h dataZ=%h expected all 0",
                  bus.memX_addr, bus.memY_addr, bus.memZ_addr, bus.memZ_data);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (z_addr_q.size() != zc || busy !== 1'b0) begin
         errors++;
         $display("FAIL midrun_nowrite: writes=%0d busy=%b expected %0d and 0", z_addr_q.size(), busy, zc);
      end
      rst_n = 1'b1;
      do_run(4, 4, 0, 100, n);
      check_4x4("after_reset", n);
   endtask

   task automatic test_start_ignored();
      int n;
      @(negedge clk);
      do_run(4, 4, 10, 100, n);
      check_4x4("restart", n);
   endtask

   initial begin
      for (int j = 0; j < 32; j++) begin
         x_mem[j] = '0;
         y_mem[j] = '0;
      end
      clear_mon();
      test_reset();
      test_basic();
      test_single_max();
      test_wrap();
      test_zero_size();
      test_reset_mid_run();
      test_start_ignored();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
